kmeans_apb_arbiter: RTL and testbench

KMEANS_APB_ARBITER -- requirements
Module: kmeans_apb_arbiter

---
 rtl/kmeans_arb_pkg.sv | 19 +
 rtl/kmeans_rr_picker.sv | 13 +
 rtl/kmeans_apb_arbiter.sv | 158 +++++++++++++++
 tb/tb_kmeans_apb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kmeans_arb_pkg.sv
// Shared defaults and FSM encoding for the two-requester APB arbiter in front of the Kmeans slave.
package kmeans_arb_pkg;

  localparam int ADDR_W_DEF      = 9;
  localparam int DATA_W_DEF      = 91;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } arb_state_e;

  // One-hot grant of two requesters to requester index.
  function automatic logic oh2idx(input logic [1:0] oh);
    return oh[1];
  endfunction

endpackage

// File: rtl/kmeans_rr_picker.sv
// Two-way round-robin choice: on a tie the requester not granted last wins.
module kmeans_rr_picker (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (&req) grant = last ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/kmeans_apb_arbiter.sv
// Arbitrates two APB requesters onto the single Kmeans APB slave, with bus lock,
// ACCESS timeout and a registered interrupt fan-out.
module kmeans_apb_arbiter
  import kmeans_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          m_psel,
  input  logic [1:0]          m_penable,
  input  logic [1:0]          m_pwrite,
  input  logic [1:0]          m_lock,
  input  logic [2*ADDR_W-1:0] m_paddr,
  input  logic [2*DATA_W-1:0] m_pwdata,
  output logic [1:0]          m_pready,
  output logic [1:0]          m_pslverr,
  output logic [DATA_W-1:0]   m_prdata,
  output logic [1:0]          m_irq,
  output logic                s_psel,
  output logic                s_penable,
  output logic                s_pwrite,
  output logic [ADDR_W-1:0]   s_paddr,
  output logic [DATA_W-1:0]   s_pwdata,
  input  logic                s_pready,
  input  logic [DATA_W-1:0]   s_prdata,
  input  logic                interupt
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  arb_state_e          state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                lock_vld_q, lock_vld_d;
  logic                lock_own_q, lock_own_d;
  logic [7:0]          wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]   s_paddr_q, s_paddr_d;
  logic [DATA_W-1:0]   s_pwdata_q, s_pwdata_d;
  logic                s_pwrite_q, s_pwrite_d;
  logic                irq_q, irq_d;

  logic [1:0]          req_eff;
  logic [1:0]          pick;
  logic                win;
  logic                done;
  logic                tmo;

  // The transfer phase is implied by the master's select; penable is not needed.
  logic unused_penable;
  assign unused_penable = ^m_penable;

  assign done = (state_q == ST_ACCESS) && s_pready;
  assign tmo  = (state_q == ST_ACCESS) && !s_pready && (wcnt_q == TMO_LAST);

  // A requesting lock owner is granted outright; an owner that still holds
  // m_lock without requesting keeps everyone else waiting.
  always_comb begin
    req_eff = m_psel;
    if (lock_vld_q) begin
      if (m_psel[lock_own_q])      req_eff = 2'b01 << lock_own_q;
      else if (m_lock[lock_own_q]) req_eff = 2'b00;
    end
  end

  kmeans_rr_picker u_pick (
    .req   (req_eff),
    .last  (last_q),
    .grant (pick)
  );

  assign win = oh2idx(pick);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    wcnt_d     = wcnt_q;
    s_paddr_d  = s_paddr_q;
    s_pwdata_d = s_pwdata_q;
    s_pwrite_d = s_pwrite_q;
    irq_d      = interupt;
    case (state_q)
      ST_IDLE: begin
        if (lock_vld_q && !m_psel[lock_own_q] && !m_lock[lock_own_q]) lock_vld_d = 1'b0;
        if (|req_eff) begin
          gnt_d      = win;
          last_d     = win;
          s_paddr_d  = win ? m_paddr[2*ADDR_W-1:ADDR_W]  : m_paddr[ADDR_W-1:0];
          s_pwdata_d = win ? m_pwdata[2*DATA_W-1:DATA_W] : m_pwdata[DATA_W-1:0];
          s_pwrite_d = win ? m_pwrite[1] : m_pwrite[0];
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        wcnt_d  = 8'd0;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (done) begin
          lock_vld_d = m_lock[gnt_q];
          lock_own_d = gnt_q;
          wcnt_d     = 8'd0;
          state_d    = ST_IDLE;
        end else if (tmo) begin
          lock_vld_d = 1'b0;
          wcnt_d     = 8'd0;
          state_d    = ST_IDLE;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      gnt_q      <= 1'b0;
      last_q     <= 1'b1;
      lock_vld_q <= 1'b0;
      lock_own_q <= 1'b0;
      wcnt_q     <= 8'd0;
      s_paddr_q  <= '0;
      s_pwdata_q <= '0;
      s_pwrite_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      wcnt_q     <= wcnt_d;
      s_paddr_q  <= s_paddr_d;
      s_pwdata_q <= s_pwdata_d;
      s_pwrite_q <= s_pwrite_d;
      irq_q      <= irq_d;
    end
  end

  assign s_psel    = (state_q != ST_IDLE);
  assign s_penable = (state_q == ST_ACCESS);
  assign s_paddr   = s_paddr_q;
  assign s_pwdata  = s_pwdata_q;
  assign s_pwrite  = s_pwrite_q;

  assign m_pready  = (done || tmo) ? (2'b01 << gnt_q) : 2'b00;
  assign m_pslverr = tmo ? (2'b01 << gnt_q) : 2'b00;
  assign m_prdata  = done ? s_prdata : '0;
  assign m_irq     = {2{irq_q}};

endmodule

// File: tb/tb_kmeans_apb_arbiter.sv
// Bench for kmeans_apb_arbiter: queued requester/slave models, scoreboard of expected completions.
module tb_kmeans_apb_arbiter;

  localparam int AW = 9;
  localparam int DW = 91;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      m_psel = '0, m_penable = '0, m_pwrite = '0, m_lock = '0;
  logic [2*AW-1:0] m_paddr = '0;
  logic [2*DW-1:0] m_pwdata = '0;
  logic [1:0]      m_pready, m_pslverr, m_irq;
  logic [DW-1:0]   m_prdata;
  logic            s_psel, s_penable, s_pwrite;
  logic [AW-1:0]   s_paddr;
  logic [DW-1:0]   s_pwdata;
  logic            s_pready = 1'b0;
  logic [DW-1:0]   s_prdata = '0;
  logic            interupt = 1'b0;

  kmeans_apb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite), .m_lock(m_lock),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_pslverr(m_pslverr), .m_prdata(m_prdata), .m_irq(m_irq),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata), .interupt(interupt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wr; logic lock; } xfer_t;
  typedef struct { logic g; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wr;
                   logic err; logic [DW-1:0] rdata; int lat; } exp_t;
  typedef struct { logic g; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic wr;
                   int wt; logic [DW-1:0] rdata; int lat; } vec_t;

  xfer_t         mq0[$], mq1[$];
  exp_t          exp_q[$];
  int            n_tests = 0, n_fail = 0, cyc = 0;
  int            slv_wait = 0, acc_cnt = 0;
  int            t_req[2];
  logic [DW-1:0] slv_rdata = '0;
  logic [1:0]    done_seen = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(input logic g, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic wr, input logic lk);
    xfer_t x;
    x = '{a, d, wr, lk};
    if (g) mq1.push_back(x); else mq0.push_back(x);
  endtask

  task automatic expect_x(input logic g, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic wr, input logic err, input logic [DW-1:0] rd, input int lat);
    exp_t e;
    e = '{g, a, d, wr, err, rd, lat};
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while ((exp_q.size() != 0 || mq0.size() != 0 || mq1.size() != 0) && n < maxc) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= maxc) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d completions still pending after %0d cycles, expected 0",
               exp_q.size(), maxc);
      exp_q.delete(); mq0.delete(); mq1.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Requesters: hold select until completion, then move on to the next queued transfer.
  always @(posedge clk) begin : mstr
    xfer_t x;
    #1;
    if (done_seen[0] && mq0.size() > 0) x = mq0.pop_front();
    if (done_seen[1] && mq1.size() > 0) x = mq1.pop_front();
    if (mq0.size() > 0) begin
      if (!m_psel[0] || done_seen[0]) t_req[0] = cyc;
      m_psel[0] = 1'b1; m_penable[0] = 1'b1;
      m_paddr[AW-1:0] = mq0[0].addr; m_pwdata[DW-1:0] = mq0[0].wdata;
      m_pwrite[0] = mq0[0].wr; m_lock[0] = mq0[0].lock;
    end else begin
      m_psel[0] = 1'b0; m_penable[0] = 1'b0; m_lock[0] = 1'b0;
    end
    if (mq1.size() > 0) begin
      if (!m_psel[1] || done_seen[1]) t_req[1] = cyc;
      m_psel[1] = 1'b1; m_penable[1] = 1'b1;
      m_paddr[2*AW-1:AW] = mq1[0].addr; m_pwdata[2*DW-1:DW] = mq1[0].wdata;
      m_pwrite[1] = mq1[0].wr; m_lock[1] = mq1[0].lock;
    end else begin
      m_psel[1] = 1'b0; m_penable[1] = 1'b0; m_lock[1] = 1'b0;
    end
    done_seen = 2'b00;
  end

  // Slave: ready after slv_wait ACCESS cycles (negative = never), read data always driven.
  always @(posedge clk) begin
    #1;
    s_prdata = slv_rdata;
    if (s_psel && s_penable) begin
      s_pready = (slv_wait >= 0) && (acc_cnt == slv_wait);
      acc_cnt++;
    end else begin
      s_pready = 1'b0;
      acc_cnt  = 0;
    end
  end

  always @(negedge clk) begin : chkr
    exp_t e;
    if (m_pready == 2'b00) chk("prdata_gate", m_prdata, '0);
    chk("slverr_gate", m_pslverr & ~m_pready, '0);
    for (int g = 0; g < 2; g++) begin
      if (m_pready[g]) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_pready: requester %0d completed, expected no completion (cycle %0d)", g, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("grant", g, e.g);
          chk("slverr", m_pslverr[g], e.err);
          chk("prdata", m_prdata, e.rdata);
          chk("s_paddr", s_paddr, e.addr);
          chk("s_pwdata", s_pwdata, e.wdata);
          chk("s_pwrite", s_pwrite, e.wr);
          if (e.lat >= 0) chk("latency", cyc - t_req[g], e.lat);
        end
      end
    end
    done_seen = m_pready;
  end

  initial begin
    vec_t vecs[4];
    int   n;
    vecs[0] = '{1'b0, 9'h010, 91'h5,                     1'b1, 0, 91'h777,     2};
    vecs[1] = '{1'b1, 9'h1FF, 91'h0,                     1'b0, 3, 91'hABC,     5};
    vecs[2] = '{1'b0, 9'h000, 91'h0,                     1'b0, 1, {91{1'b1}},  3};
    vecs[3] = '{1'b1, 9'h155, 91'h4_0000_0000_0000_0001, 1'b1, 2, 91'h123,     4};

    // Reset state
    #2;
    chk("rst_s_psel", s_psel, 0);
    chk("rst_s_penable", s_penable, 0);
    chk("rst_m_pready", m_pready, 0);
    chk("rst_m_pslverr", m_pslverr, 0);
    chk("rst_m_irq", m_irq, 0);
    chk("rst_m_prdata", m_prdata, 0);
    chk("rst_s_paddr", s_paddr, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Round robin after reset: 0,1,0,1
    slv_wait = 0; slv_rdata = 91'h11;
    @(negedge clk);
    send(0, 9'h020, 91'hA0, 1, 0); send(0, 9'h021, 91'hA1, 0, 0);
    send(1, 9'h030, 91'hB0, 1, 0); send(1, 9'h031, 91'hB1, 0, 0);
    expect_x(0, 9'h020, 91'hA0, 1, 0, 91'h11, 2);
    expect_x(1, 9'h030, 91'hB0, 1, 0, 91'h11, 5);
    expect_x(0, 9'h021, 91'hA1, 0, 0, 91'h11, 5);
    expect_x(1, 9'h031, 91'hB1, 0, 0, 91'h11, 5);
    wait_drain(100);

    // Lock: m1 holds bus for four reads while m0 waits
    slv_rdata = 91'h22;
    send(1, 9'h040, 91'h0, 0, 1); send(1, 9'h041, 91'h0, 0, 1);
    send(1, 9'h042, 91'h0, 0, 1); send(1, 9'h043, 91'h0, 0, 0);
    for (int i = 0; i < 4; i++) expect_x(1, 9'h040 + 9'(i), 91'h0, 0, 0, 91'h22, -1);
    expect_x(0, 9'h050, 91'h55, 1, 0, 91'h22, -1);
    n = 0;
    while (!s_psel && n < 10) begin @(negedge clk); n++; end
    chk("lock_m1_first", s_psel, 1);
    send(0, 9'h050, 91'h55, 1, 0);
    wait_drain(200);

    // Single-transfer vectors
    for (int i = 0; i < 4; i++) begin
      slv_wait = vecs[i].wt; slv_rdata = vecs[i].rdata;
      send(vecs[i].g, vecs[i].addr, vecs[i].wdata, vecs[i].wr, 0);
      expect_x(vecs[i].g, vecs[i].addr, vecs[i].wdata, vecs[i].wr, 0, vecs[i].rdata, vecs[i].lat);
      wait_drain(50);
    end

    // Timeout after 255 ACCESS cycles, then a normal transfer
    slv_wait = -1; slv_rdata = 91'hDEAD;
    send(0, 9'h060, 91'h66, 1, 0);
    expect_x(0, 9'h060, 91'h66, 1, 1, 91'h0, 256);
    wait_drain(400);
    slv_wait = 0;
    send(1, 9'h070, 91'h0, 0, 0);
    expect_x(1, 9'h070, 91'h0, 0, 0, 91'hDEAD, 2);
    wait_drain(50);

    // Reset during ACCESS aborts the transfer
    slv_wait = -1;
    send(0, 9'h080, 91'h88, 1, 0);
    n = 0;
    while (!s_penable && n < 10) begin @(negedge clk); n++; end
    chk("abort_in_access", s_penable, 1);
    rst_n = 1'b0;
    mq0.delete();
    #1;
    chk("abort_s_psel", s_psel, 0);
    chk("abort_s_penable", s_penable, 0);
    chk("abort_m_pready", m_pready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_psel", s_psel, 0);

    // Interrupt forwarded one flop later
    @(posedge clk); #1 interupt = 1'b1;
    @(negedge clk);
    chk("irq_before", m_irq, 2'b00);
    @(posedge clk); #1 interupt = 1'b0;
    @(negedge clk);
    chk("irq_pulse", m_irq, 2'b11);
    @(negedge clk);
    chk("irq_after", m_irq, 2'b00);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
